alu_result_buffer: RTL and testbench
====================================

Name: alu_result_buffer

Overview:
- Downstream stage of the 16-bit structural ALU. Captures each ALU result word Z and its five flags (Sign, Zero, Carry, Parity, Overflow) through a valid/ready handshake.
- Queues captured results in a small FIFO for the consumer (register file / writeback).
- Keeps a sticky status register and an operation counter for software and debug visibility.

Parameters:
- W, 16, result width; matches the ALU datapath width.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- CNT_W, 16, width of the accepted-operation counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  ALU result and flags present this cycle.
- in_ready  out  1  buffer can accept an entry.
- Z  in  W  ALU result word.
- Sign, Zero, Carry, Parity, Overflow  in  1 each  ALU flags for Z.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer takes head entry.
- out_Z  out  W  head result word.
- out_flags  out  5  head flags, packed {Sign,Zero,Carry,Parity,Overflow} (bit 4 down to bit 0).
- level  out  log2(DEPTH)+1  current number of stored entries.
- sticky  out  5  OR of flags of all accepted entries since the last clear; same packing as out_flags.
- sticky_clr  in  1  single-cycle pulse; clears sticky.
- op_count  out  CNT_W  number of accepted entries, modulo 2^CNT_W.

Behaviour:
- Reset:
  - rst=1 asynchronously forces rd_ptr=0, wr_ptr=0, level=0, sticky=0, op_count=0 and all storage to 0.
  - Outputs under reset: out_valid=0, in_ready=1, out_Z=0, out_flags=0.
  - Reset mid-operation discards all stored entries. A handshake coinciding with the reset edge is lost.
- Push:
  - Occurs when in_valid and in_ready are both high at a rising edge.
  - {Z, flags} is written to mem[wr_ptr] and wr_ptr increments, wrapping modulo DEPTH.
- Pop:
  - Occurs when out_valid and out_ready are both high at a rising edge.
  - rd_ptr increments, wrapping modulo DEPTH.
- Head output: out_Z/out_flags are a combinational read of mem[rd_ptr]. When out_valid=0 they hold stale data and must not be used.
- Latency: an entry pushed at edge k shows out_valid=1 and its data in the cycle after edge k. There is no same-cycle input-to-output bypass.
- Occupancy flags:
  - in_ready = (level != DEPTH).
  - out_valid = (level != 0).
  - Both depend only on registered state, never on out_ready or in_valid.
- Level update: push only gives +1; pop only gives -1; push and pop in the same edge leave level unchanged. When the buffer is full, push cannot occur (in_ready=0) even if a pop happens that cycle.
- Full/empty boundaries:
  - in_valid while full is held off; the producer must keep Z and flags stable until accepted.
  - out_ready while empty has no effect.
- Flag packing: flags are stored exactly as presented. The block does not recompute or check them against Z.
- sticky:
  - On push, sticky <= sticky | incoming flags.
  - On sticky_clr without a push, sticky <= 0.
  - On sticky_clr and a push in the same edge, sticky <= incoming flags; the clear applies first, then the new entry.
- op_count: +1 on each push; wraps from 2^CNT_W-1 to 0. It is unaffected by pops and by sticky_clr.
- Handshake rule: no combinational path from in_valid to in_ready, or from out_ready to out_valid.

Test Plan:
- Reset then single push: Z=16'h8000, Sign=1, Zero=0, Carry=0, Parity=0, Overflow=1 (0x7FFF+0x0001).
  - Next cycle: out_valid=1, out_Z=16'h8000, out_flags=5'b10001, level=1, op_count=1, sticky=5'b10001.
- Second push: Z=16'h0000, flags 5'b01110 (0xFFFF+0x0001).
  - sticky=5'b11111 and level=2.
  - Pop twice with out_ready=1: entries appear in push order, then out_valid=0 and level=0.
- Fill to DEPTH=4 with out_ready=0:
  - in_ready drops after the 4th push.
  - A 5th in_valid is held off and op_count stays 4.
  - One pop gives in_ready=1 the next cycle; the held entry is then accepted and appears last, in order.
- Simultaneous push and pop at level=2: level stays 2 and FIFO order is preserved across the wr_ptr/rd_ptr wrap (run 10 such cycles).
- sticky_clr alone gives sticky=0. sticky_clr with a push of flags 5'b00100 gives sticky=5'b00100.
- Assert rst with level=3 mid-stream: immediately out_valid=0, level=0, op_count=0, sticky=0, in_ready=1. After release, the first push behaves as in the first scenario.

Source files
------------

// File: rtl/alu_result_buffer.sv
// rtl/alu_result_buffer.sv - ALU result/flag FIFO with sticky status and op counter
// Captures {Z, flags} from the ALU through valid/ready and presents the head to writeback.
module alu_result_buffer #(
    parameter int W     = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [W-1:0]               Z,
    input  logic                       Sign,
    input  logic                       Zero,
    input  logic                       Carry,
    input  logic                       Parity,
    input  logic                       Overflow,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [W-1:0]               out_Z,
    output logic [4:0]                 out_flags,
    output logic [$clog2(DEPTH):0]     level,
    output logic [4:0]                 sticky,
    input  logic                       sticky_clr,
    output logic [CNT_W-1:0]           op_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int EW = W + 5;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [EW-1:0]    mem_q [DEPTH];
    logic [EW-1:0]    mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [4:0]       sticky_q, sticky_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    logic       push;
    logic       pop;
    logic [4:0] in_flags;

    // Handshake flags come only from registered occupancy, so no in->out combinational path.
    assign in_ready  = (level_q != FULL_LVL);
    assign out_valid = (level_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign in_flags  = {Sign, Zero, Carry, Parity, Overflow};

    assign out_Z     = mem_q[rd_ptr_q][EW-1:5];
    assign out_flags = mem_q[rd_ptr_q][4:0];
    assign level     = level_q;
    assign sticky    = sticky_q;
    assign op_count  = op_count_q;

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        sticky_d   = sticky_q;
        op_count_d = op_count_q;

        if (push) begin
            mem_d[wr_ptr_q] = {Z, in_flags};
            wr_ptr_d        = wr_ptr_q + PW'(1);
            op_count_d      = op_count_q + CNT_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (!push && pop) begin
            level_d = level_q - LW'(1);
        end

        // Clear takes effect before the same-edge entry is folded in.
        if (sticky_clr) begin
            sticky_d = '0;
        end
        if (push) begin
            sticky_d = sticky_d | in_flags;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            sticky_q   <= '0;
            op_count_q <= '0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            sticky_q   <= sticky_d;
            op_count_q <= op_count_d;
        end
    end

endmodule

// File: tb/tb_alu_result_buffer.sv
// tb/tb_alu_result_buffer.sv - self-checking bench for alu_result_buffer
module tb_alu_result_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] z = '0;
    logic [4:0]  f = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_Z;
    logic [4:0]  out_flags;
    logic [2:0]  level;
    logic [4:0]  sticky;
    logic        sticky_clr = 1'b0;
    logic [15:0] op_count;

    int checks = 0;
    int errors = 0;

    logic [20:0] m_q[$];
    logic [4:0]  m_sticky;
    logic [15:0] m_cnt;
    logic        m_last_push;

    typedef struct {
        logic        iv;
        logic [15:0] z;
        logic [4:0]  f;
        logic        ordy;
        logic        clr;
        logic        ev;
        logic [15:0] ez;
        logic [4:0]  ef;
        logic [2:0]  el;
        logic [4:0]  es;
        logic [15:0] ec;
    } vec_t;

    vec_t tbl[7];

    always #5 clk = ~clk;

    alu_result_buffer #(.W(16), .DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .Z(z), .Sign(f[4]), .Zero(f[3]), .Carry(f[2]), .Parity(f[1]), .Overflow(f[0]),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_Z(out_Z), .out_flags(out_flags), .level(level),
        .sticky(sticky), .sticky_clr(sticky_clr), .op_count(op_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        m_sticky    = '0;
        m_cnt       = '0;
        m_last_push = 1'b0;
    endtask

    task automatic check_model();
        check("m_out_valid", 32'(out_valid), 32'(m_q.size() != 0));
        check("m_in_ready", 32'(in_ready), 32'(m_q.size() != DEPTH));
        check("m_level", 32'(level), 32'(m_q.size()));
        check("m_op_count", 32'(op_count), 32'(m_cnt));
        check("m_sticky", 32'(sticky), 32'(m_sticky));
        if (m_q.size() != 0) begin
            check("m_out_Z", 32'(out_Z), 32'(m_q[0][20:5]));
            check("m_out_flags", 32'(out_flags), 32'(m_q[0][4:0]));
        end
    endtask

    // One clock: reference decides accept/take from queue occupancy, then compares.
    task automatic cycle();
        logic do_push, do_pop;
        do_push = in_valid && (m_q.size() < DEPTH);
        do_pop  = out_ready && (m_q.size() > 0);
        @(posedge clk);
        if (do_pop) void'(m_q.pop_front());
        if (do_push) m_q.push_back({z, f});
        if (sticky_clr) m_sticky = '0;
        if (do_push) m_sticky = m_sticky | f;
        if (do_push) m_cnt = m_cnt + 16'd1;
        m_last_push = do_push;
        #1;
        check_model();
    endtask

    task automatic idle();
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        sticky_clr = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    initial begin
        model_clear();
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_Z", 32'(out_Z), 32'd0);
        check("rst_out_flags", 32'(out_flags), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        check("rst_sticky", 32'(sticky), 32'd0);
        do_reset();

        // iv z f ordy clr | ev ez ef el es ec
        tbl[0] = '{1'b1, 16'h8000, 5'b10001, 1'b0, 1'b0, 1'b1, 16'h8000, 5'b10001, 3'd1, 5'b10001, 16'd1};
        tbl[1] = '{1'b1, 16'h0000, 5'b01110, 1'b0, 1'b0, 1'b1, 16'h8000, 5'b10001, 3'd2, 5'b11111, 16'd2};
        tbl[2] = '{1'b0, 16'h0000, 5'b00000, 1'b1, 1'b0, 1'b1, 16'h0000, 5'b01110, 3'd1, 5'b11111, 16'd2};
        tbl[3] = '{1'b0, 16'h0000, 5'b00000, 1'b1, 1'b0, 1'b0, 16'h0000, 5'b00000, 3'd0, 5'b11111, 16'd2};
        tbl[4] = '{1'b0, 16'h0000, 5'b00000, 1'b0, 1'b1, 1'b0, 16'h0000, 5'b00000, 3'd0, 5'b00000, 16'd2};
        tbl[5] = '{1'b1, 16'h1234, 5'b00100, 1'b0, 1'b1, 1'b1, 16'h1234, 5'b00100, 3'd1, 5'b00100, 16'd3};
        tbl[6] = '{1'b0, 16'h0000, 5'b00000, 1'b1, 1'b0, 1'b0, 16'h0000, 5'b00000, 3'd0, 5'b00100, 16'd3};
        for (int i = 0; i < 7; i++) begin
            in_valid   = tbl[i].iv;
            z          = tbl[i].z;
            f          = tbl[i].f;
            out_ready  = tbl[i].ordy;
            sticky_clr = tbl[i].clr;
            cycle();
            check("tbl_out_valid", 32'(out_valid), 32'(tbl[i].ev));
            check("tbl_level", 32'(level), 32'(tbl[i].el));
            check("tbl_sticky", 32'(sticky), 32'(tbl[i].es));
            check("tbl_op_count", 32'(op_count), 32'(tbl[i].ec));
            if (tbl[i].ev) begin
                check("tbl_out_Z", 32'(out_Z), 32'(tbl[i].ez));
                check("tbl_out_flags", 32'(out_flags), 32'(tbl[i].ef));
            end
        end
        idle();

        // Fill to full, hold off a fifth entry, free one slot, then drain in order.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            z = 16'hA000 + 16'(i);
            f = 5'(i + 1);
            cycle();
        end
        check("full_in_ready", 32'(in_ready), 32'd0);
        z = 16'hBEEF;
        f = 5'b11011;
        cycle();
        cycle();
        check("held_op_count", 32'(op_count), 32'd4);
        check("held_level", 32'(level), 32'd4);
        out_ready = 1'b1;
        cycle();
        check("after_pop_in_ready", 32'(in_ready), 32'd1);
        check("after_pop_op_count", 32'(op_count), 32'd4);
        out_ready = 1'b0;
        cycle();
        check("held_accept_op_count", 32'(op_count), 32'd5);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        check("last_out_Z", 32'(out_Z), 32'h0000BEEF);
        check("last_out_flags", 32'(out_flags), 32'b11011);
        cycle();
        check("drained_valid", 32'(out_valid), 32'd0);
        idle();

        // Steady push+pop at level 2 across pointer wrap.
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            z = 16'($urandom);
            f = 5'($urandom);
            cycle();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            z = 16'($urandom);
            f = 5'($urandom);
            cycle();
            check("pp_level", 32'(level), 32'd2);
        end
        idle();

        // Asynchronous reset mid-stream with three entries stored.
        in_valid = 1'b1;
        z = 16'h0F0F;
        f = 5'b00010;
        cycle();
        in_valid = 1'b0;
        check("pre_rst_level", 32'(level), 32'd3);
        rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_level", 32'(level), 32'd0);
        check("arst_op_count", 32'(op_count), 32'd0);
        check("arst_sticky", 32'(sticky), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        in_valid = 1'b1;
        z = 16'h8000;
        f = 5'b10001;
        cycle();
        in_valid = 1'b0;
        check("post_rst_out_Z", 32'(out_Z), 32'h00008000);
        check("post_rst_out_flags", 32'(out_flags), 32'b10001);
        check("post_rst_level", 32'(level), 32'd1);
        check("post_rst_op_count", 32'(op_count), 32'd1);
        check("post_rst_sticky", 32'(sticky), 32'b10001);

        // Random traffic; a held-off producer keeps its word stable until accepted.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (!(in_valid && !m_last_push)) begin
                in_valid = 1'($urandom);
                z = 16'($urandom);
                f = 5'($urandom);
            end
            out_ready  = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            sticky_clr = ($urandom_range(0, 7) == 0);
            cycle();
        end
        idle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
